// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: execute-stage sequencer for the shared multiplier and divider.
// Issues one MULT/MULTU/DIV/DIVU at a time, stalls the pipe, writes HI/LO once.
module muldiv_ctrl #(
  parameter logic [31:0] DIV0_LO  = 32'hFFFF_FFFF,
  parameter int unsigned WDOG_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        mul_opn_valid_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_sign_o,
  input  logic        mul_res_valid_i,
  output logic        mul_res_ready_o,
  input  logic [63:0] mul_result_i,
  output logic        div_opn_valid_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_sign_o,
  input  logic        div_res_valid_i,
  output logic        div_res_ready_o,
  input  logic [63:0] div_result_i,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wdog_err_o
);

  // state     | meaning
  // S_IDLE    | no operation; accepts req_valid & ~flush
  // S_ISSUE   | one-cycle opn_valid to the selected unit
  // S_WAIT    | waiting for the selected res_valid; watchdog runs
  // S_DONE    | one-cycle HI/LO write
  // S_DRAIN   | flushed op: consume and discard the unit result
  // S_RELEASE | wait for the unit to drop res_valid before going idle
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN, S_RELEASE
  } state_e;

  localparam int CW = $clog2(WDOG_CYC + 1);

  state_e        state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          div_q, div_d, sign_q, sign_d;
  logic          issued_q, issued_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          sel_res_valid, take;
  logic [63:0]   sel_result;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      issued_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div_q    <= div_d;
      sign_q   <= sign_d;
      issued_q <= issued_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign sel_res_valid = div_q ? div_res_valid_i : mul_res_valid_i;
  assign sel_result    = div_q ? div_result_i    : mul_result_i;

  always_comb begin
    state_d         = state_q;
    a_d             = a_q;
    b_d             = b_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    div_d           = div_q;
    sign_d          = sign_q;
    issued_d        = issued_q;
    cnt_d           = cnt_q;
    err_d           = err_q;
    stall_req_o     = 1'b0;
    mul_opn_valid_o = 1'b0;
    div_opn_valid_o = 1'b0;
    hilo_we_o       = 1'b0;
    take            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          stall_req_o = 1'b1;
          a_d         = req_a_i;
          b_d         = req_b_i;
          div_d       = req_op_i[1];
          sign_d      = ~req_op_i[0];
          if (req_op_i[1] && (req_b_i == '0)) begin
            hi_d     = req_a_i;
            lo_d     = DIV0_LO;
            issued_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            issued_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // The pulse goes out even when flushed so DRAIN always has a result to consume.
        stall_req_o     = 1'b1;
        mul_opn_valid_o = ~div_q;
        div_opn_valid_o = div_q;
        cnt_d           = '0;
        state_d         = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        stall_req_o = 1'b1;
        if (flush_i) begin
          state_d = S_DRAIN;
        end else if (sel_res_valid) begin
          take    = 1'b1;
          hi_d    = sel_result[63:32];
          lo_d    = sel_result[31:0];
          state_d = S_DONE;
        end else begin
          if (cnt_q != CW'(WDOG_CYC)) cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WDOG_CYC - 1)) err_d = 1'b1;
        end
      end
      S_DONE: begin
        hilo_we_o = 1'b1;
        state_d   = issued_q ? S_RELEASE : S_IDLE;
      end
      S_DRAIN: begin
        stall_req_o = req_valid_i;
        if (sel_res_valid) begin
          take    = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        stall_req_o = req_valid_i;
        if (!sel_res_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    mul_res_ready_o = take & ~div_q;
    div_res_ready_o = take & div_q;
  end

  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;
  assign mul_sign_o = sign_q;
  assign div_a_o    = a_q;
  assign div_b_o    = b_q;
  assign div_sign_o = sign_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign wdog_err_o = err_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural multiplier/divider models, reference
// arithmetic for HI/LO, and per-scenario checks of latency and handshakes.
module tb_muldiv_ctrl;
  localparam logic [31:0] DIV0_LO  = 32'hFFFF_FFFF;
  localparam int          WDOG_CYC = 255;
  localparam int          MUL_LAT  = 3;

  logic clk = 1'b0, rst_n = 1'b1;
  logic req_valid = 0, flush = 0;
  logic [1:0] req_op = 0;
  logic [31:0] req_a = 0, req_b = 0;
  logic stall_req, mul_opn_valid, mul_sign, mul_res_valid, mul_res_ready;
  logic div_opn_valid, div_sign, div_res_valid, div_res_ready;
  logic [31:0] mul_a, mul_b, div_a, div_b, hi_o, lo_o;
  logic [63:0] mul_result, div_result;
  logic hilo_we, wdog_err;
  logic [200:0] all_outs;

  int n_tests = 0, n_fail = 0;
  int div_lat = 33;
  bit div_never = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.DIV0_LO(DIV0_LO), .WDOG_CYC(WDOG_CYC)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .flush_i(flush), .stall_req_o(stall_req),
    .mul_opn_valid_o(mul_opn_valid), .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_sign_o(mul_sign),
    .mul_res_valid_i(mul_res_valid), .mul_res_ready_o(mul_res_ready), .mul_result_i(mul_result),
    .div_opn_valid_o(div_opn_valid), .div_a_o(div_a), .div_b_o(div_b), .div_sign_o(div_sign),
    .div_res_valid_i(div_res_valid), .div_res_ready_o(div_res_ready), .div_result_i(div_result),
    .hilo_we_o(hilo_we), .hi_o(hi_o), .lo_o(lo_o), .wdog_err_o(wdog_err)
  );

  assign all_outs = {stall_req, mul_opn_valid, mul_a, mul_b, mul_sign, mul_res_ready,
                     div_opn_valid, div_a, div_b, div_sign, div_res_ready,
                     hilo_we, hi_o, lo_o, wdog_err};

  function automatic logic [63:0] arith(input bit is_div, input bit sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (!is_div) return 64'(sa * sb);
    if (b == 0) return 64'h0;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [63:0] ref_hilo(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    if (op[1] && b == 0) return {a, DIV0_LO};
    return arith(op[1], !op[0], a, b);
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
    if (!op[1]) return MUL_LAT + 2;
    if (b == 0) return 1;
    return div_lat + 2;
  endfunction

  // Unit models: result after a fixed latency, res_valid held one cycle past the handshake.
  logic m_valid, m_post, d_valid, d_post;
  int m_cnt, d_cnt;
  logic [63:0] m_pend, d_pend;
  assign mul_res_valid = m_valid;
  assign div_res_valid = d_valid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_post <= 0; m_cnt <= 0; m_pend <= '0; mul_result <= '0;
    end else begin
      if (m_post) begin m_valid <= 0; m_post <= 0; end
      else if (m_valid && mul_res_ready) m_post <= 1;
      if (m_cnt == 1) begin m_valid <= 1; mul_result <= m_pend; end
      if (m_cnt > 0) m_cnt <= m_cnt - 1;
      if (mul_opn_valid) begin m_cnt <= MUL_LAT - 1; m_pend <= arith(0, mul_sign, mul_a, mul_b); end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid <= 0; d_post <= 0; d_cnt <= 0; d_pend <= '0; div_result <= '0;
    end else begin
      if (d_post) begin d_valid <= 0; d_post <= 0; end
      else if (d_valid && div_res_ready) d_post <= 1;
      if (d_cnt == 1 && !div_never) begin d_valid <= 1; div_result <= d_pend; end
      if (d_cnt > 0) d_cnt <= d_cnt - 1;
      if (div_opn_valid) begin d_cnt <= div_lat - 1; d_pend <= arith(1, div_sign, div_a, div_b); end
    end
  end

  // Presents one request for one cycle and observes the DUT until it settles back in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int lat,
                        output int nmul, output int ndiv, output int nwe,
                        output bit stall_ok, output bit sign_seen, output bit done_stall);
    hi = 0; lo = 0; lat = -1; nmul = 0; ndiv = 0; nwe = 0;
    stall_ok = 1; sign_seen = 0; done_stall = 1;
    @(negedge clk);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    #1 if (stall_req !== 1'b1) stall_ok = 0;
    for (int i = 1; i < 400; i++) begin
      @(negedge clk);
      if (mul_opn_valid === 1'b1) begin nmul++; sign_seen = mul_sign; end
      if (div_opn_valid === 1'b1) begin ndiv++; sign_seen = div_sign; end
      if (hilo_we === 1'b1) begin
        nwe++;
        if (lat < 0) begin lat = i; hi = hi_o; lo = lo_o; done_stall = stall_req; end
      end else if (lat < 0 && stall_req !== 1'b1) stall_ok = 0;
      req_valid = 0;
      if (lat >= 0 && i >= lat + 3) break;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 n_tests++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL reset_outs: got %h required 0", all_outs); end
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    n_tests++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL idle_outs: got %h required 0", all_outs); end
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo; int lat, nm, nd, nw; bit sok, sg, ds;
    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, hi, lo, lat, nm, nd, nw, sok, sg, ds);
    n_tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      n_fail++; $display("FAIL mult_hilo: got %h required %h", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA); end
    n_tests++;
    if ({nm, nd, nw} !== {32'd1, 32'd0, 32'd1}) begin
      n_fail++; $display("FAIL mult_pulses: got mul=%0d div=%0d we=%0d required 1/0/1", nm, nd, nw); end
    n_tests++;
    if (sg !== 1'b1) begin n_fail++; $display("FAIL mult_sign: got %b required 1", sg); end
    n_tests++;
    if (lat != 5) begin n_fail++; $display("FAIL mult_latency: got %0d required 5", lat); end
    n_tests++;
    if (ds !== 1'b0 || sok !== 1'b1) begin
      n_fail++; $display("FAIL mult_stall: done_stall=%b stall_ok=%b required 0/1", ds, sok); end
  endtask

  task automatic test_multu();
    logic [31:0] hi, lo; int lat, nm, nd, nw; bit sok, sg, ds;
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, hi, lo, lat, nm, nd, nw, sok, sg, ds);
    n_tests++;
    if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin
      n_fail++; $display("FAIL multu_hilo: got %h required %h", {hi, lo}, 64'h0000_0001_FFFF_FFFE); end
    n_tests++;
    if ({nm, nd, sg} !== {32'd1, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL multu_issue: got mul=%0d div=%0d sign=%b required 1/0/0", nm, nd, sg); end
  endtask

  task automatic test_divu();
    logic [31:0] hi, lo; int lat, nm, nd, nw; bit sok, sg, ds;
    div_lat = 33;
    run_op(2'd3, 32'd17, 32'd5, hi, lo, lat, nm, nd, nw, sok, sg, ds);
    n_tests++;
    if ({hi, lo} !== {32'd2, 32'd3}) begin
      n_fail++; $display("FAIL divu_hilo: got %h required %h", {hi, lo}, {32'd2, 32'd3}); end
    n_tests++;
    if (lat != 35 || sok !== 1'b1) begin
      n_fail++; $display("FAIL divu_latency: got lat=%0d stall_ok=%b required 35/1", lat, sok); end
    n_tests++;
    if ({nm, nd, nw, sg} !== {32'd0, 32'd1, 32'd1, 1'b0}) begin
      n_fail++; $display("FAIL divu_pulses: got mul=%0d div=%0d we=%0d sign=%b required 0/1/1/0", nm, nd, nw, sg); end
    n_tests++;
    if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL divu_wdog: got %b required 0", wdog_err); end
  endtask

  task automatic test_div_zero();
    logic [31:0] hi, lo; int lat, nm, nd, nw; bit sok, sg, ds;
    run_op(2'd2, 32'd9, 32'd0, hi, lo, lat, nm, nd, nw, sok, sg, ds);
    n_tests++;
    if ({hi, lo} !== {32'd9, 32'hFFFF_FFFF}) begin
      n_fail++; $display("FAIL div0_hilo: got %h required %h", {hi, lo}, {32'd9, 32'hFFFF_FFFF}); end
    n_tests++;
    if ({nm, nd, nw, lat} !== {32'd0, 32'd0, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL div0_timing: got mul=%0d div=%0d we=%0d lat=%0d required 0/0/1/1", nm, nd, nw, lat); end
  endtask

  task automatic test_random();
    logic [1:0] op; logic [31:0] a, b, hi, lo; logic [63:0] exp;
    int lat, nm, nd, nw, em, ed, exp_lat; bit sok, sg, ds;
    for (int k = 0; k < 24; k++) begin
      op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 7));
        default: ;
      endcase
      div_lat = $urandom_range(2, 40);
      exp = ref_hilo(op, a, b);
      exp_lat = ref_lat(op, b);
      em = op[1] ? 0 : 1;
      ed = (op[1] && b != 0) ? 1 : 0;
      run_op(op, a, b, hi, lo, lat, nm, nd, nw, sok, sg, ds);
      n_tests++;
      if ({hi, lo} !== exp) begin
        n_fail++; $display("FAIL rand_hilo op=%0d a=%h b=%h: got %h required %h", op, a, b, {hi, lo}, exp); end
      n_tests++;
      if (lat != exp_lat || sok !== 1'b1 || ds !== 1'b0) begin
        n_fail++; $display("FAIL rand_timing op=%0d: got lat=%0d stall_ok=%b done_stall=%b required %0d/1/0", op, lat, sok, ds, exp_lat); end
      n_tests++;
      if ({nm, nd, nw} !== {em, ed, 32'd1}) begin
        n_fail++; $display("FAIL rand_pulses op=%0d: got mul=%0d div=%0d we=%0d required %0d/%0d/1", op, nm, nd, nw, em, ed); end
      if (em + ed > 0) begin
        n_tests++;
        if (sg !== ~op[0]) begin n_fail++; $display("FAIL rand_sign op=%0d: got %b required %b", op, sg, ~op[0]); end
      end
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    req_valid = 1; req_op = 2'd0; req_a = 32'd5; req_b = 32'd6; flush = 1;
    #1 n_tests++;
    if (stall_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b required 0", stall_req); end
    @(negedge clk);
    n_tests++;
    if ({mul_opn_valid, hilo_we} !== 2'b00) begin
      n_fail++; $display("FAIL flush_idle_accept: got opn=%b we=%b required 0/0", mul_opn_valid, hilo_we); end
    req_valid = 0; flush = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_flush_drain();
    logic [31:0] a2, b2, hi, lo; logic [63:0] exp;
    int early_we, n_rdy, opn_at, we_at; bit stall_bad;
    early_we = 0; n_rdy = 0; opn_at = -1; we_at = -1; stall_bad = 0; hi = 0; lo = 0;
    a2 = $urandom; b2 = $urandom | 32'd1; div_lat = 33;
    exp = ref_hilo(2'd3, a2, b2);
    @(negedge clk);
    req_valid = 1; req_op = 2'd0; req_a = $urandom; req_b = $urandom;
    for (int i = 1; i < 200; i++) begin
      @(negedge clk);
      if (hilo_we === 1'b1) begin
        if (opn_at < 0) early_we++;
        else if (we_at < 0) begin we_at = i; hi = hi_o; lo = lo_o; end
      end
      if (mul_res_ready === 1'b1) n_rdy++;
      if (div_opn_valid === 1'b1 && opn_at < 0) opn_at = i;
      if (i >= 5 && opn_at < 0 && stall_req !== 1'b1) stall_bad = 1;
      if (i == 1) req_valid = 0;
      if (i == 3) flush = 1;
      if (i == 4) begin flush = 0; req_valid = 1; req_op = 2'd3; req_a = a2; req_b = b2; end
      if (opn_at >= 0) req_valid = 0;
      if (we_at >= 0 && i >= we_at + 3) break;
    end
    n_tests++;
    if (early_we != 0 || n_rdy != 1) begin
      n_fail++; $display("FAIL drain_handshake: got we=%0d res_ready=%0d required 0/1", early_we, n_rdy); end
    n_tests++;
    if (opn_at != 8 || stall_bad) begin
      n_fail++; $display("FAIL drain_next_issue: got cycle %0d stall_bad=%b required 8/0", opn_at, stall_bad); end
    n_tests++;
    if (we_at != 8 + div_lat + 1 || {hi, lo} !== exp) begin
      n_fail++; $display("FAIL drain_next_result: got cycle %0d data %h required %0d %h", we_at, {hi, lo}, 8 + div_lat + 1, exp); end
  endtask

  task automatic test_flush_done();
    logic [31:0] a, b, hi, lo; int nw, we_at;
    a = $urandom; b = $urandom; nw = 0; we_at = -1; hi = 0; lo = 0;
    @(negedge clk);
    req_valid = 1; req_op = 2'd0; req_a = a; req_b = b;
    for (int i = 1; i < 12; i++) begin
      if (i == 5) begin @(posedge clk); #1 flush = 1; end
      @(negedge clk);
      if (hilo_we === 1'b1) begin nw++; we_at = i; hi = hi_o; lo = lo_o; end
      req_valid = 0; flush = 0;
    end
    n_tests++;
    if (nw != 1 || we_at != 5 || {hi, lo} !== ref_hilo(2'd0, a, b)) begin
      n_fail++; $display("FAIL flush_done: got we=%0d at %0d data %h required 1 at 5 %h", nw, we_at, {hi, lo}, ref_hilo(2'd0, a, b)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, hi2, lo2; int opn1, opn2, we2; bit st5, st6;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    opn1 = -1; opn2 = -1; we2 = -1; hi2 = 0; lo2 = 0; st5 = 1; st6 = 0;
    @(negedge clk);
    req_valid = 1; req_op = 2'd1; req_a = a1; req_b = b1;
    for (int i = 1; i < 60; i++) begin
      @(negedge clk);
      if (mul_opn_valid === 1'b1) begin if (opn1 < 0) opn1 = i; else if (opn2 < 0) opn2 = i; end
      if (hilo_we === 1'b1 && opn2 >= 0 && we2 < 0) begin we2 = i; hi2 = hi_o; lo2 = lo_o; end
      if (i == 5) st5 = stall_req;
      if (i == 6) st6 = stall_req;
      if (i == 1) begin req_op = 2'd0; req_a = a2; req_b = b2; end
      if (opn2 >= 0) req_valid = 0;
      if (we2 >= 0 && i >= we2 + 3) break;
    end
    n_tests++;
    if (opn1 != 1 || opn2 != 8) begin
      n_fail++; $display("FAIL b2b_spacing: got issue cycles %0d,%0d required 1,8", opn1, opn2); end
    n_tests++;
    if ({st5, st6} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_stall: got done=%b release=%b required 0/1", st5, st6); end
    n_tests++;
    if (we2 != 12 || {hi2, lo2} !== ref_hilo(2'd0, a2, b2)) begin
      n_fail++; $display("FAIL b2b_result: got cycle %0d data %h required 12 %h", we2, {hi2, lo2}, ref_hilo(2'd0, a2, b2)); end
  endtask

  task automatic test_watchdog_reset();
    bit e256, e257, e300, s300;
    e256 = 1; e257 = 0; e300 = 0; s300 = 0;
    div_never = 1; div_lat = 10;
    @(negedge clk);
    req_valid = 1; req_op = 2'd3; req_a = 32'd100; req_b = 32'd7;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 256) e256 = wdog_err;
      if (i == 257) e257 = wdog_err;
      if (i == 300) begin e300 = wdog_err; s300 = stall_req; end
      req_valid = 0;
    end
    n_tests++;
    if ({e256, e257} !== 2'b01) begin
      n_fail++; $display("FAIL wdog_timing: got err@256=%b err@257=%b required 0/1", e256, e257); end
    n_tests++;
    if ({e300, s300} !== 2'b11) begin
      n_fail++; $display("FAIL wdog_sticky: got err=%b stall=%b required 1/1", e300, s300); end
    #2 rst_n = 0;
    #1 n_tests++;
    if (all_outs !== '0) begin n_fail++; $display("FAIL async_reset: got %h required 0", all_outs); end
    div_never = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (wdog_err !== 1'b0) begin n_fail++; $display("FAIL wdog_after_reset: got %b required 0", wdog_err); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_divu();
    test_div_zero();
    test_random();
    test_flush_idle();
    test_flush_drain();
    test_flush_done();
    test_back_to_back();
    test_watchdog_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Execute-stage sequencer for the shared multiplier and divider units.
- Accepts MULT/MULTU/DIV/DIVU requests and issues each to the correct unit over its opn_valid/res_valid/res_ready handshake.
- Holds the pipeline stall while the operation is outstanding, then writes the 64-bit result into HI/LO with a one-cycle write pulse.
- Handles pipeline flush mid-operation and divide-by-zero.

Parameters:
- DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.
- WDOG_CYC, 255, cycles in WAIT with no res_valid before the sticky error flag sets.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX stage presents an operation.
- req_op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- req_a  in  32  rs operand.
- req_b  in  32  rt operand.
- flush  in  1  exception/flush; kill the current operation.
- stall_req  out  1  freeze pipeline.
- mul_opn_valid  out  1  start pulse to multiplier.
- mul_a, mul_b  out  32  multiplier operands.
- mul_sign  out  1  1 = signed.
- mul_res_valid  in  1  multiplier result ready.
- mul_res_ready  out  1  accept multiplier result.
- mul_result  in  64  {hi,lo}.
- div_opn_valid, div_a, div_b, div_sign, div_res_valid, div_res_ready, div_result: same widths and meaning for the divider; div_result = {remainder, quotient}.
- hilo_we  out  1  HI/LO write strobe.
- hi_o, lo_o  out  32  HI/LO write data.
- wdog_err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0 (all *_opn_valid, *_res_ready, hilo_we, hi_o, lo_o, operand outputs, wdog_err).
- Registers: operands, op and target unit are captured on acceptance. Unit operand and sign outputs are driven from these registers and stay stable until the operation completes.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN, RELEASE.
- IDLE:
  - Accept when req_valid & ~flush.
  - DIV/DIVU with req_b==0: no issue; go to DONE with hi=req_a, lo=DIV0_LO.
  - Otherwise go to ISSUE.
- ISSUE: the selected *_opn_valid is high for exactly one cycle; other unit idle; go to WAIT.
- WAIT:
  - On the selected *_res_valid: assert *_res_ready for that one cycle and latch the result. Mult: hi=result[63:32], lo=result[31:0]. Div: hi=remainder, lo=quotient. Go to DONE.
  - The unselected unit's res_valid is ignored.
- DONE: hilo_we=1 for one cycle with hi_o/lo_o valid.
  - Went through ISSUE: go to RELEASE.
  - Divide-by-zero (no unit issued): go to IDLE.
- RELEASE: wait until the selected *_res_valid deasserts (units hold res_valid one cycle after the handshake), then go to IDLE. Nothing new is issued here, so a stale res_valid is never consumed.
- flush:
  - In ISSUE or WAIT: go to DRAIN.
  - In DONE: hilo_we still fires, because the instruction already committed past EX.
  - In IDLE: the request is not accepted.
- DRAIN: wait for the selected res_valid, pulse res_ready, discard the data, no hilo_we; then go to RELEASE. Flush takes priority over a res_valid arriving in the same WAIT cycle: that result is consumed in DRAIN and discarded.
- stall_req (combinational):
  - 1 when IDLE & req_valid & ~flush.
  - 1 in ISSUE and WAIT.
  - 0 in DONE.
  - In DRAIN/RELEASE it equals req_valid, so a new request waits.
- Watchdog: counter clears on entering WAIT and increments each WAIT cycle. When it reaches WDOG_CYC, wdog_err sets and stays set until reset; the FSM keeps waiting.
- Latency, acceptance to hilo_we:
  - 1 (ISSUE) + unit latency to res_valid + 1 (DONE).
  - Multiplier: res_valid 3 cycles after opn_valid, so hilo_we is 5 cycles after acceptance.
- Back-to-back: minimum spacing between acceptances is one DONE cycle plus one RELEASE cycle. Sign follows op: MULT/DIV signed, MULTU/DIVU unsigned.

Test Plan:
- MULT a=0xFFFF_FFFE(-2), b=3 -> mul_opn_valid pulse with mul_sign=1; hilo_we once; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA; stall_req low in the DONE cycle.
- MULTU a=0xFFFF_FFFF, b=2 -> hi=0x0000_0001, lo=0xFFFF_FFFE; div_opn_valid never asserted.
- DIVU a=17, b=5 (divider model returns after 33 cycles) -> hi=2, lo=3; stall_req high throughout the wait; wdog_err stays 0.
- DIV a=9, b=0 -> no opn_valid on either unit; hilo_we one cycle later with hi=9, lo=0xFFFF_FFFF.
- MULT in flight, flush in the 2nd WAIT cycle -> res_ready handshake completes, no hilo_we. A DIVU issued right after is accepted only after res_valid drops, and gives the correct result.
- Async reset asserted mid-WAIT -> all outputs 0 immediately. A divider model that never responds -> wdog_err=1 after 255 WAIT cycles and stays set.
